// File: rtl/seq_detect_ctrl.sv
// -----------------------------------------------------------------------------
// seq_detect_ctrl
//
// Purpose:
//   Sequences one external serial pattern detector (DATA_SIZE-bit loadable
//   pattern, 1-bit shift-in every cycle, registered compare). It accepts a
//   pattern/hit-limit configuration, pulses the detector load for one cycle,
//   streams serial bits into the detector under valid/ready, qualifies raw
//   detector hits against the window fill, counts qualified matches, and
//   stops after the programmed hit limit.
//
// Ports:
//   clk, reset                  single clock, synchronous active-high reset
//   cfg_valid/cfg_ready         configuration handshake
//   cfg_pattern                 pattern, bit0 = oldest serial bit
//   cfg_max_hits                hits before DONE (0 = unlimited)
//   abort                       return to IDLE from any state
//   bit_valid/bit_ready/bit_data serial bit stream handshake
//   det_load, det_seq, det_din  drive the detector (load, pattern, serial in)
//   det_hit                     raw hit from the detector
//   match_pulse                 one-cycle qualified match
//   hit_count                   qualified matches since last configuration
//   busy                        state is LOAD or RUN
//   done                        state is DONE
// -----------------------------------------------------------------------------
module seq_detect_ctrl #(
    parameter int DATA_SIZE = 4,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [DATA_SIZE-1:0] cfg_pattern,
    input  logic [CNT_W-1:0]     cfg_max_hits,
    input  logic                 abort,
    input  logic                 bit_valid,
    output logic                 bit_ready,
    input  logic                 bit_data,
    output logic                 det_load,
    output logic [DATA_SIZE-1:0] det_seq,
    output logic                 det_din,
    input  logic                 det_hit,
    output logic                 match_pulse,
    output logic [CNT_W-1:0]     hit_count,
    output logic                 busy,
    output logic                 done
);

    // Fill counts accepted bits up to DATA_SIZE, so it needs to hold DATA_SIZE.
    localparam int FILL_W = $clog2(DATA_SIZE + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic [DATA_SIZE-1:0] r_pattern;
    logic [CNT_W-1:0]     r_max_hits;
    logic [CNT_W-1:0]     r_hit_count;
    logic [FILL_W-1:0]    r_fill;
    logic                 r_win_d1;
    logic                 r_win_d2;
    logic                 r_match_pulse;

    logic                 w_cfg_fire;
    logic                 w_bit_acc;
    logic                 w_win_ok;
    logic                 w_qual;
    logic                 w_stop;
    logic [CNT_W-1:0]     w_hit_inc;

    // -------------------------------------------------------------------------
    // Datapath-side combinational terms
    // -------------------------------------------------------------------------
    assign w_bit_acc  = bit_valid && (r_state == S_RUN);
    assign w_cfg_fire = cfg_valid && cfg_ready;

    // The window holds DATA_SIZE real bits once this accepted bit lands,
    // i.e. when fill+1 >= DATA_SIZE.
    assign w_win_ok   = w_bit_acc && (r_fill >= FILL_W'(DATA_SIZE - 1));

    // Raw hits only count when the matching window was fully made of
    // accepted bits; the 2-cycle delay lines up with the detector latency.
    assign w_qual     = (r_state == S_RUN) && det_hit && r_win_d2;

    assign w_hit_inc  = (r_hit_count == '1) ? r_hit_count
                                            : r_hit_count + CNT_W'(1);

    assign w_stop     = w_qual && (r_max_hits != '0) && (w_hit_inc == r_max_hits);

    // The detector shifts every cycle, so idle cycles push zeros.
    assign det_din     = w_bit_acc ? bit_data : 1'b0;
    assign det_seq     = r_pattern;
    assign match_pulse = r_match_pulse;
    assign hit_count   = r_hit_count;

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state and Moore-style outputs
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        cfg_ready    = 1'b0;
        bit_ready    = 1'b0;
        det_load     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;

        case (r_state)
            S_IDLE: begin
                cfg_ready = !abort;
                if (cfg_valid && !abort) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                det_load     = 1'b1;
                busy         = 1'b1;
                w_next_state = S_RUN;
            end
            S_RUN: begin
                bit_ready = 1'b1;
                busy      = 1'b1;
                if (w_stop) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                cfg_ready = !abort;
                done      = 1'b1;
                if (cfg_valid && !abort) begin
                    w_next_state = S_LOAD;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        // Abort overrides every transition, including a config handshake.
        if (abort) begin
            w_next_state = S_IDLE;
        end
    end

    // -------------------------------------------------------------------------
    // Configuration, fill, qualifier pipeline and hit counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pattern     <= '0;
            r_max_hits    <= '0;
            r_hit_count   <= '0;
            r_fill        <= '0;
            r_win_d1      <= 1'b0;
            r_win_d2      <= 1'b0;
            r_match_pulse <= 1'b0;
        end else begin
            if (w_cfg_fire) begin
                r_pattern   <= cfg_pattern;
                r_max_hits  <= cfg_max_hits;
                r_hit_count <= '0;
            end else if (w_qual && !abort) begin
                r_hit_count <= w_hit_inc;
            end

            r_match_pulse <= w_qual && !abort;

            // A RUN cycle without an accepted bit shifts a zero into the
            // detector, which breaks the window, so fill restarts.
            if ((r_state == S_RUN) && !abort && w_bit_acc) begin
                if (r_fill != FILL_W'(DATA_SIZE)) begin
                    r_fill <= r_fill + FILL_W'(1);
                end
            end else begin
                r_fill <= '0;
            end

            // Leaving RUN (DONE, abort) drops any hits still in flight.
            if (w_next_state == S_RUN) begin
                r_win_d1 <= w_win_ok;
                r_win_d2 <= r_win_d1;
            end else begin
                r_win_d1 <= 1'b0;
                r_win_d2 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_ctrl
//
// Directed bench for seq_detect_ctrl. Contains a behavioural model of the
// external detector: pattern register loaded on det_load, shift register
// taking det_din every cycle (newest bit enters at the MSB so bit0 is the
// oldest), and a registered compare driving det_hit.
// -----------------------------------------------------------------------------
module tb_seq_detect_ctrl;

    localparam int DATA_SIZE = 4;
    localparam int CNT_W     = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [DATA_SIZE-1:0] cfg_pattern;
    logic [CNT_W-1:0]     cfg_max_hits;
    logic                 abort;
    logic                 bit_valid;
    logic                 bit_ready;
    logic                 bit_data;
    logic                 det_load;
    logic [DATA_SIZE-1:0] det_seq;
    logic                 det_din;
    logic                 det_hit;
    logic                 match_pulse;
    logic [CNT_W-1:0]     hit_count;
    logic                 busy;
    logic                 done;

    int errors = 0;
    int checks = 0;

    // Per-cycle observations from the last stream, index = RUN cycle.
    logic [31:0]      pulse_v;
    logic [31:0]      done_v;
    logic [31:0]      brdy_v;
    logic [CNT_W-1:0] hc_v [32];

    // Observations from the last configuration sequence.
    logic                 cfgr_obs;
    logic                 ld_obs;
    logic                 busy_obs;
    logic [CNT_W-1:0]     hc_obs;
    logic [DATA_SIZE-1:0] seq_obs;

    // Detector model
    logic [DATA_SIZE-1:0] m_seq;
    logic [DATA_SIZE-1:0] m_q;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) begin
            m_seq   <= '0;
            m_q     <= '0;
            det_hit <= 1'b0;
        end else begin
            if (det_load) m_seq <= det_seq;
            m_q     <= {det_din, m_q[DATA_SIZE-1:1]};
            det_hit <= (m_q == m_seq);
        end
    end

    seq_detect_ctrl #(
        .DATA_SIZE (DATA_SIZE),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_pattern  (cfg_pattern),
        .cfg_max_hits (cfg_max_hits),
        .abort        (abort),
        .bit_valid    (bit_valid),
        .bit_ready    (bit_ready),
        .bit_data     (bit_data),
        .det_load     (det_load),
        .det_seq      (det_seq),
        .det_din      (det_din),
        .det_hit      (det_hit),
        .match_pulse  (match_pulse),
        .hit_count    (hit_count),
        .busy         (busy),
        .done         (done)
    );

    // ------------------------------------------------------------------ helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    // Handshake cycle, then the LOAD cycle; returns at the start of RUN cycle 0.
    task automatic do_cfg(input logic [DATA_SIZE-1:0] pat, input logic [CNT_W-1:0] max_hits);
        cfg_valid    = 1'b1;
        cfg_pattern  = pat;
        cfg_max_hits = max_hits;
        #1;
        cfgr_obs = cfg_ready;
        tick();
        cfg_valid = 1'b0;
        #1;
        ld_obs   = det_load;
        busy_obs = busy;
        hc_obs   = hit_count;
        seq_obs  = det_seq;
        tick();
    endtask

    task automatic run_stream(input int n, input logic [31:0] vld, input logic [31:0] dat);
        pulse_v = '0;
        done_v  = '0;
        brdy_v  = '0;
        for (int i = 0; i < n; i++) begin
            bit_valid = vld[i];
            bit_data  = dat[i];
            #1;
            pulse_v[i] = match_pulse;
            done_v[i]  = done;
            brdy_v[i]  = bit_ready;
            hc_v[i]    = hit_count;
            tick();
        end
        bit_valid = 1'b0;
        bit_data  = 1'b0;
    endtask

    // -------------------------------------------------------------------- tests
    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
        checks++;
        if (hit_count !== '0) begin errors++; $display("FAIL reset_hit_count got=%0d exp=0", hit_count); end
        checks++;
        if (det_load !== 1'b0 || bit_ready !== 1'b0 || match_pulse !== 1'b0) begin
            errors++; $display("FAIL reset_strobes load/bready/pulse got=%b%b%b exp=000", det_load, bit_ready, match_pulse);
        end
        checks++;
        if (det_seq !== '0 || det_din !== 1'b0) begin errors++; $display("FAIL reset_det_seq got=%h/%b exp=0/0", det_seq, det_din); end
    endtask

    task automatic test_basic_match();
        do_cfg(4'b1011, 8'd0);
        checks++;
        if (cfgr_obs !== 1'b1) begin errors++; $display("FAIL basic_cfg_ready got=%b exp=1", cfgr_obs); end
        checks++;
        if (ld_obs !== 1'b1 || busy_obs !== 1'b1 || seq_obs !== 4'b1011) begin
            errors++; $display("FAIL basic_load load/busy/seq got=%b/%b/%h exp=1/1/b", ld_obs, busy_obs, seq_obs);
        end
        // Bits 1,1,0,1 in RUN cycles 0..3; 4th bit at cycle 3 -> pulse at cycle 6.
        run_stream(16, 32'h0000_000F, 32'h0000_000B);
        checks++;
        if (pulse_v[15:0] !== 16'h0040) begin errors++; $display("FAIL basic_pulses got=%h exp=0040", pulse_v[15:0]); end
        checks++;
        if (hc_v[5] !== 8'd0 || hc_v[6] !== 8'd1 || hc_v[15] !== 8'd1) begin
            errors++; $display("FAIL basic_hit_count c5/c6/c15 got=%0d/%0d/%0d exp=0/1/1", hc_v[5], hc_v[6], hc_v[15]);
        end
        checks++;
        if (brdy_v[15:0] !== 16'hFFFF) begin errors++; $display("FAIL basic_bit_ready got=%h exp=ffff", brdy_v[15:0]); end
    endtask

    task automatic test_overlap();
        do_abort();
        do_cfg(4'b1111, 8'd0);
        checks++;
        if (hc_obs !== 8'd0) begin errors++; $display("FAIL overlap_cfg_clear got=%0d exp=0", hc_obs); end
        // Six 1s in cycles 0..5: full windows at cycles 3,4,5 -> pulses 6,7,8.
        run_stream(16, 32'h0000_003F, 32'h0000_003F);
        checks++;
        if (pulse_v[15:0] !== 16'h01C0) begin errors++; $display("FAIL overlap_pulses got=%h exp=01c0", pulse_v[15:0]); end
        checks++;
        if (hc_v[15] !== 8'd3) begin errors++; $display("FAIL overlap_hit_count got=%0d exp=3", hc_v[15]); end
    endtask

    task automatic test_gap();
        do_abort();
        do_cfg(4'b1011, 8'd0);
        // 1,1, gap, 0,1: the window never holds a full run of accepted bits.
        run_stream(16, 32'h0000_001B, 32'h0000_0013);
        checks++;
        if (pulse_v[15:0] !== 16'h0000 || hc_v[15] !== 8'd0) begin
            errors++; $display("FAIL gap_no_match pulses=%h count=%0d exp=0000/0", pulse_v[15:0], hc_v[15]);
        end
        // det_din follows bit_data only while bit_valid is high.
        bit_valid = 1'b1;
        bit_data  = 1'b1;
        #1;
        checks++;
        if (det_din !== 1'b1) begin errors++; $display("FAIL gap_din_valid got=%b exp=1", det_din); end
        bit_valid = 1'b0;
        #1;
        checks++;
        if (det_din !== 1'b0) begin errors++; $display("FAIL gap_din_idle got=%b exp=0", det_din); end
        bit_data = 1'b0;

        // Pattern 0000: detector hits continuously, but the gap at cycle 2
        // restarts fill, so only cycle 6 completes a window -> pulse at 9.
        do_abort();
        do_cfg(4'b0000, 8'd0);
        run_stream(16, 32'h0000_007B, 32'h0000_0000);
        checks++;
        if (pulse_v[15:0] !== 16'h0200) begin errors++; $display("FAIL gap_fill_restart got=%h exp=0200", pulse_v[15:0]); end
        checks++;
        if (hc_v[15] !== 8'd1) begin errors++; $display("FAIL gap_fill_count got=%0d exp=1", hc_v[15]); end
    endtask

    task automatic test_max_hits();
        do_abort();
        do_cfg(4'b0000, 8'd2);
        // Continuous 0s: pulses at 6,7; DONE from cycle 7, later hits dropped.
        run_stream(12, 32'h0000_0FFF, 32'h0000_0000);
        checks++;
        if (pulse_v[11:0] !== 12'h0C0) begin errors++; $display("FAIL max_pulses got=%h exp=0c0", pulse_v[11:0]); end
        checks++;
        if (done_v[11:0] !== 12'hF80) begin errors++; $display("FAIL max_done got=%h exp=f80", done_v[11:0]); end
        checks++;
        if (brdy_v[11:0] !== 12'h07F) begin errors++; $display("FAIL max_bit_ready got=%h exp=07f", brdy_v[11:0]); end
        checks++;
        if (hc_v[6] !== 8'd1 || hc_v[7] !== 8'd2 || hc_v[11] !== 8'd2) begin
            errors++; $display("FAIL max_hit_count c6/c7/c11 got=%0d/%0d/%0d exp=1/2/2", hc_v[6], hc_v[7], hc_v[11]);
        end
        tick();
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || hit_count !== 8'd2) begin
            errors++; $display("FAIL max_hold done/busy/count got=%b/%b/%0d exp=1/0/2", done, busy, hit_count);
        end
    endtask

    task automatic test_abort();
        // DONE accepts a new config and clears the count.
        do_cfg(4'b1111, 8'd0);
        checks++;
        if (cfgr_obs !== 1'b1 || hc_obs !== 8'd0) begin
            errors++; $display("FAIL abort_cfg_from_done ready/count got=%b/%0d exp=1/0", cfgr_obs, hc_obs);
        end
        run_stream(9, 32'h0000_001F, 32'h0000_001F);
        checks++;
        if (hc_v[8] !== 8'd2) begin errors++; $display("FAIL abort_pre_count got=%0d exp=2", hc_v[8]); end

        abort        = 1'b1;
        cfg_valid    = 1'b1;
        cfg_pattern  = 4'b0101;
        cfg_max_hits = 8'd1;
        #1;
        checks++;
        if (cfg_ready !== 1'b0) begin errors++; $display("FAIL abort_cfg_ready got=%b exp=0", cfg_ready); end
        tick();
        abort     = 1'b0;
        cfg_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1 || det_load !== 1'b0) begin
            errors++; $display("FAIL abort_idle busy/done/ready/load got=%b/%b/%b/%b exp=0/0/1/0", busy, done, cfg_ready, det_load);
        end
        checks++;
        if (hit_count !== 8'd2 || det_seq !== 4'b1111) begin
            errors++; $display("FAIL abort_hold count/seq got=%0d/%h exp=2/f", hit_count, det_seq);
        end

        do_cfg(4'b0101, 8'd0);
        checks++;
        if (ld_obs !== 1'b1 || hc_obs !== 8'd0 || seq_obs !== 4'b0101) begin
            errors++; $display("FAIL abort_recfg load/count/seq got=%b/%0d/%h exp=1/0/5", ld_obs, hc_obs, seq_obs);
        end
    endtask

    task automatic test_reset_mid_run();
        run_stream(3, 32'h0000_0007, 32'h0000_0005);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0 || bit_ready !== 1'b0 || det_seq !== '0 || hit_count !== '0) begin
            errors++; $display("FAIL reset_mid_run ready/busy/bready/seq/count got=%b/%b/%b/%h/%0d exp=1/0/0/0/0",
                               cfg_ready, busy, bit_ready, det_seq, hit_count);
        end
    endtask

    initial begin
        reset        = 1'b1;
        cfg_valid    = 1'b0;
        cfg_pattern  = '0;
        cfg_max_hits = '0;
        abort        = 1'b0;
        bit_valid    = 1'b0;
        bit_data     = 1'b0;

        test_reset();
        test_basic_match();
        test_overlap();
        test_gap();
        test_max_hits();
        test_abort();
        test_reset_mid_run();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
